ram_seq_ctrl: RTL

RAM_SEQ_CTRL -- requirements
Module: ram_seq_ctrl

---
 rtl/ram_seq_pkg.sv | 17 +
 rtl/ram_rd_skid.sv | 59 +++++
 rtl/ram_seq_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ram_seq_pkg.sv
// Shared constants and the controller state type for the sample-buffer
// capture/playback sequencer.
package ram_seq_pkg;

  // Buffer geometry: words held, address width, sample width.
  localparam int DEPTH = 87424;
  localparam int AW    = 17;
  localparam int DW    = 16;

  // Controller operating modes.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    PLAY    = 2'd2
  } seq_state_t;

endpackage

// File: rtl/ram_rd_skid.sv
// Two-entry skid FIFO that absorbs RAM read data while the playback
// consumer stalls. Flush empties it immediately and wins over push/pop.
module ram_rd_skid #(
  parameter int DW = ram_seq_pkg::DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          valid,
  output logic [DW-1:0] head,
  output logic [1:0]    count
);

  logic [DW-1:0] mem [2];
  logic          wr_idx;
  logic          rd_idx;
  logic [1:0]    cnt;
  logic          do_push;
  logic          do_pop;

  // A push into a full FIFO is only accepted when the head leaves in the
  // same cycle; a pop of an empty FIFO is ignored.
  always_comb begin
    do_pop  = pop && (cnt != 2'd0);
    do_push = push && ((cnt != 2'd2) || do_pop);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_idx <= 1'b0;
      rd_idx <= 1'b0;
      cnt    <= 2'd0;
    end else if (flush) begin
      wr_idx <= 1'b0;
      rd_idx <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_idx] <= push_data;
        wr_idx      <= ~wr_idx;
      end
      if (do_pop) begin
        rd_idx <= ~rd_idx;
      end
      cnt <= cnt + 2'(do_push) - 2'(do_pop);
    end
  end

  assign valid = (cnt != 2'd0);
  assign head  = mem[rd_idx];
  assign count = cnt;

endmodule

// File: rtl/ram_seq_ctrl.sv
// Capture/playback sequencer for a single-port sample RAM.
// Capture streams cap_data into RAM from address 0; playback streams the
// last completed capture back out, optionally looping until abort.
//
// Stream handshakes (capture and playback alike): a word transfers in a
// cycle where valid and ready are both 1 at the rising clock edge; valid
// never depends on ready, and data is held while valid=1 and ready=0.
module ram_seq_ctrl #(
  parameter int DEPTH = ram_seq_pkg::DEPTH,
  parameter int AW    = ram_seq_pkg::AW,
  parameter int DW    = ram_seq_pkg::DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cap_start,
  input  logic          play_start,
  input  logic          play_loop,
  input  logic          abort,
  input  logic [AW-1:0] cap_len,
  input  logic          cap_valid,
  input  logic [DW-1:0] cap_data,
  output logic          cap_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic [AW-1:0] stored_len,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] ram_addr,
  output logic          ram_wr_en,
  output logic [DW-1:0] ram_wr_data,
  output logic          ram_rd_en,
  input  logic [DW-1:0] ram_rd_data
);

  import ram_seq_pkg::*;

  localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);

  seq_state_t    state;
  seq_state_t    state_nxt;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] len_r;
  logic [AW-1:0] stored_len_r;
  logic [AW-1:0] len_clamped;
  logic          loop_r;
  logic          rd_inflight;
  logic          rd_finished;
  logic          done_r;

  logic          skid_valid;
  logic [DW-1:0] skid_head;
  logic [1:0]    skid_count;
  logic          skid_pop;
  logic          skid_flush;
  logic [1:0]    occupancy;
  logic          wr_last;
  logic          rd_last;
  logic          play_last_pop;

  // Requested capture length saturates at the buffer size.
  assign len_clamped = (cap_len > DEPTH_W) ? DEPTH_W : cap_len;

  // Words that will sit in the skid once this cycle's pop and the
  // outstanding read settle; counting the pop keeps one word per cycle.
  assign skid_pop   = skid_valid && out_ready;
  assign occupancy  = 2'(rd_inflight) + skid_count - 2'(skid_pop);
  assign skid_flush = abort && (state != IDLE);

  assign wr_last = (wr_ptr == len_r - AW'(1));
  assign rd_last = (rd_ptr == stored_len_r - AW'(1));

  // The final non-looping word leaves: no read pending and nothing behind it.
  assign play_last_pop = skid_pop && rd_finished && !rd_inflight &&
                         (skid_count == 2'd1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and RAM/stream port decode; abort overrides everything else.
  always_comb begin
    state_nxt   = state;
    cap_ready   = 1'b0;
    ram_wr_en   = 1'b0;
    ram_rd_en   = 1'b0;
    ram_addr    = '0;
    ram_wr_data = '0;
    unique case (state)
      IDLE: begin
        if (!abort) begin
          if (cap_start) begin
            if (len_clamped != '0) state_nxt = CAPTURE;
          end else if (play_start) begin
            if (stored_len_r != '0) state_nxt = PLAY;
          end
        end
      end
      CAPTURE: begin
        cap_ready = 1'b1;
        if (cap_valid) begin
          ram_wr_en   = 1'b1;
          ram_addr    = wr_ptr;
          ram_wr_data = cap_data;
        end
        if (abort) begin
          state_nxt = IDLE;
        end else if (cap_valid && wr_last) begin
          state_nxt = IDLE;
        end
      end
      PLAY: begin
        if (!abort && !rd_finished && (occupancy < 2'd2)) begin
          ram_rd_en = 1'b1;
          ram_addr  = rd_ptr;
        end
        if (abort || play_last_pop) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pointers, lengths, loop mode and the registered done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      len_r        <= '0;
      stored_len_r <= '0;
      loop_r       <= 1'b0;
      rd_finished  <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!abort) begin
            if (cap_start) begin
              wr_ptr <= '0;
              len_r  <= len_clamped;
              if (len_clamped == '0) begin
                stored_len_r <= '0;
                done_r       <= 1'b1;
              end
            end else if (play_start) begin
              rd_ptr      <= '0;
              loop_r      <= play_loop;
              rd_finished <= 1'b0;
              if (stored_len_r == '0) done_r <= 1'b1;
            end
          end
        end
        CAPTURE: begin
          if (!abort && cap_valid) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (wr_last) begin
              stored_len_r <= len_r;
              done_r       <= 1'b1;
            end
          end
        end
        PLAY: begin
          if (ram_rd_en) begin
            if (rd_last) begin
              if (loop_r) rd_ptr <= '0;
              else        rd_finished <= 1'b1;
            end else begin
              rd_ptr <= rd_ptr + AW'(1);
            end
          end
          if (!abort && play_last_pop) done_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A read issued this cycle returns data next cycle; abort suppresses the
  // read, so nothing is left in flight afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_inflight <= 1'b0;
    end else begin
      rd_inflight <= ram_rd_en;
    end
  end

  ram_rd_skid #(.DW(DW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (skid_flush),
    .push      (rd_inflight),
    .push_data (ram_rd_data),
    .pop       (skid_pop),
    .valid     (skid_valid),
    .head      (skid_head),
    .count     (skid_count)
  );

  assign out_valid  = skid_valid;
  assign out_data   = skid_valid ? skid_head : '0;
  assign stored_len = stored_len_r;
  assign busy       = (state != IDLE);
  assign done       = done_r;

endmodule
